// File: rtl/sm83_irq_ctl_if.sv
// Core-side register bus between the sm83 core and its interrupt controller.
// The core is the master: it drives the address, write data and strobes.
// The controller is the slave: it returns read data and an output enable.
interface sm83_irq_ctl_if;
  logic [15:0] adr;
  logic [7:0]  din;
  logic [7:0]  dout;
  logic        dout_oe;
  logic        p_rd;
  logic        p_wr;

  modport master (
    output adr, din, p_rd, p_wr,
    input  dout, dout_oe
  );

  modport slave (
    input  adr, din, p_rd, p_wr,
    output dout, dout_oe
  );
endinterface

// File: rtl/sm83_irq_ctl.sv
// sm83 interrupt controller.
// Rising edges on peripheral source lines set bits in the interrupt-flag
// register IF. IF is masked with the interrupt-enable register IE to form
// the registered irq vector. The core acknowledges through iack. IF and IE
// are memory mapped on the core bus. Writes are captured while the strobe
// is high and committed on the cycle after it falls, because din is only
// guaranteed stable during the strobe.
module sm83_irq_ctl #(
  parameter int unsigned          NUM_IRQS  = 8,
  parameter logic [NUM_IRQS-1:0]  IMPL_MASK = 8'h1F,
  parameter logic [15:0]          IF_ADR    = 16'hFF0F,
  parameter logic [15:0]          IE_ADR    = 16'hFFFF
) (
  input  logic                clk,
  input  logic                n_reset,
  sm83_irq_ctl_if.slave       bus,
  input  logic [NUM_IRQS-1:0] src,
  output logic [NUM_IRQS-1:0] irq,
  input  logic [NUM_IRQS-1:0] iack,
  output logic                irq_any
);

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_IF   = 2'd1,
    SEL_IE   = 2'd2
  } sel_e;

  logic [NUM_IRQS-1:0] src_q;
  logic [NUM_IRQS-1:0] if_q, if_d;
  logic [NUM_IRQS-1:0] ie_q, ie_d;
  logic [NUM_IRQS-1:0] irq_q;
  logic [NUM_IRQS-1:0] rise;
  logic [NUM_IRQS-1:0] wr_if_val;
  logic [7:0]          wr_buf_q, wr_buf_d;
  sel_e                wr_sel_q, wr_sel_d;
  logic                p_wr_q;
  logic                hit_if, hit_ie;
  logic                commit;

  assign hit_if    = (bus.adr == IF_ADR);
  assign hit_ie    = (bus.adr == IE_ADR);
  assign commit    = p_wr_q & ~bus.p_wr;
  assign rise      = src & ~src_q & IMPL_MASK;
  assign wr_if_val = NUM_IRQS'(wr_buf_q) & IMPL_MASK;

  // Write capture, commit decode and IF/IE next-state (edge beats write beats iack).
  always_comb begin
    wr_buf_d = wr_buf_q;
    wr_sel_d = wr_sel_q;
    ie_d     = ie_q;
    if_d     = if_q;

    // The last matching address seen during the strobe wins.
    if (bus.p_wr && hit_if) begin
      wr_buf_d = bus.din;
      wr_sel_d = SEL_IF;
    end else if (bus.p_wr && hit_ie) begin
      wr_buf_d = bus.din;
      wr_sel_d = SEL_IE;
    end else if (commit) begin
      // Clearing the selection here stops a later strobe that never hits
      // IF or IE from replaying this write.
      wr_sel_d = SEL_NONE;
    end

    if (commit && (wr_sel_q == SEL_IE)) begin
      ie_d = NUM_IRQS'(wr_buf_q);
    end

    for (int i = 0; i < int'(NUM_IRQS); i++) begin
      if (rise[i]) begin
        if_d[i] = 1'b1;
      end else if (commit && (wr_sel_q == SEL_IF)) begin
        if_d[i] = wr_if_val[i];
      end else if (iack[i]) begin
        if_d[i] = 1'b0;
      end
    end
  end

  // State registers; irq is registered from next-state IF and IE.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      src_q    <= '0;
      if_q     <= '0;
      ie_q     <= '0;
      irq_q    <= '0;
      wr_buf_q <= '0;
      wr_sel_q <= SEL_NONE;
      p_wr_q   <= 1'b0;
    end else begin
      src_q    <= src;
      if_q     <= if_d;
      ie_q     <= ie_d;
      irq_q    <= if_d & ie_d & IMPL_MASK;
      wr_buf_q <= wr_buf_d;
      wr_sel_q <= wr_sel_d;
      p_wr_q   <= bus.p_wr;
    end
  end

  // Side-effect-free register read. Unimplemented IF bits read as 1.
  // The read is blanked while reset is asserted.
  always_comb begin
    bus.dout_oe = 1'b0;
    bus.dout    = '0;
    if (n_reset && bus.p_rd) begin
      if (hit_if) begin
        bus.dout_oe = 1'b1;
        bus.dout    = 8'(if_q | ~IMPL_MASK);
      end else if (hit_ie) begin
        bus.dout_oe = 1'b1;
        bus.dout    = 8'(ie_q);
      end
    end
  end

  assign irq     = irq_q;
  assign irq_any = |irq_q;

endmodule

// File: tb/tb_sm83_irq_ctl.sv
// Directed testbench for sm83_irq_ctl.
// Stimulus pushes hand-computed expectations into queues. A monitor pops
// one entry whenever the DUT drives read data, or when the stimulus asks
// for an irq sample, and compares it on the falling clock edge.
module tb_sm83_irq_ctl;

  typedef struct {
    string      name;
    logic [7:0] val;
  } exp_t;

  logic       clk = 1'b0;
  logic       n_reset = 1'b1;
  logic [7:0] src = '0;
  logic [7:0] iack = '0;
  logic [7:0] irq;
  logic       irq_any;
  logic       irq_req = 1'b0;

  int n_chk  = 0;
  int n_fail = 0;

  exp_t rd_q[$];
  exp_t irq_q[$];

  sm83_irq_ctl_if bus();

  sm83_irq_ctl dut (
    .clk     (clk),
    .n_reset (n_reset),
    .bus     (bus),
    .src     (src),
    .irq     (irq),
    .iack    (iack),
    .irq_any (irq_any)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", n, act, exp, $time);
    end
  endtask

  // Monitor: compare read data and requested irq samples on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (bus.dout_oe) begin
      if (rd_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_read: got dout %h, expected no read (t=%0t)", bus.dout, $time);
      end else begin
        e = rd_q.pop_front();
        chk(e.name, bus.dout, e.val);
      end
    end
    if (irq_req) begin
      if (irq_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL irq_sample: got irq %h, expected an entry in the queue", irq);
      end else begin
        e = irq_q.pop_front();
        chk(e.name, irq, e.val);
        chk({e.name, "_any"}, {7'b0, irq_any}, {7'b0, |e.val});
      end
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_rd(input string n, input logic [7:0] v);
    exp_t e;
    e.name = n;
    e.val  = v;
    rd_q.push_back(e);
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    bus.adr  = a;
    bus.din  = d;
    bus.p_wr = 1'b1;
    cyc();
    bus.p_wr = 1'b0;
    bus.adr  = '0;
    cyc();
  endtask

  task automatic rd(input string n, input logic [15:0] a, input logic [7:0] v);
    push_rd(n, v);
    bus.adr  = a;
    bus.p_rd = 1'b1;
    cyc();
    bus.p_rd = 1'b0;
    bus.adr  = '0;
  endtask

  task automatic chk_irq(input string n, input logic [7:0] v);
    exp_t e;
    e.name = n;
    e.val  = v;
    irq_q.push_back(e);
    irq_req = 1'b1;
    cyc();
    irq_req = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.adr  = '0;
    bus.din  = '0;
    bus.p_rd = 1'b0;
    bus.p_wr = 1'b0;

    // Reset state
    #1 n_reset = 1'b0;
    #2;
    chk("rst_irq", irq, 8'h00);
    chk("rst_irq_any", {7'b0, irq_any}, 8'h00);
    chk("rst_dout_oe", {7'b0, bus.dout_oe}, 8'h00);
    chk("rst_dout", bus.dout, 8'h00);
    cyc(2);
    #2 n_reset = 1'b1;
    cyc();

    // Edge detect: a held level sets IF once
    wr(16'hFFFF, 8'h1F);
    src = 8'h04;
    cyc();
    rd("t1_if_set", 16'hFF0F, 8'hE4);
    chk_irq("t1_irq", 8'h04);
    iack = 8'h04;
    cyc();
    iack = 8'h00;
    cyc();
    chk_irq("t1_irq_ack", 8'h00);
    rd("t1_if_ack", 16'hFF0F, 8'hE0);
    cyc(5);
    rd("t1_if_hold", 16'hFF0F, 8'hE0);
    src = 8'h00;
    cyc();

    // CPU write/read; a read in the commit cycle sees the old value
    bus.adr  = 16'hFFFF;
    bus.din  = 8'h15;
    bus.p_wr = 1'b1;
    cyc();
    bus.p_wr = 1'b0;
    bus.p_rd = 1'b1;
    push_rd("t2_ie_precommit", 8'h1F);
    cyc();
    bus.p_rd = 1'b0;
    rd("t2_ie", 16'hFFFF, 8'h15);
    // Address changes mid-strobe: the IF hit comes last and wins
    bus.adr  = 16'hFFFF;
    bus.din  = 8'hAA;
    bus.p_wr = 1'b1;
    cyc();
    bus.adr  = 16'hFF0F;
    bus.din  = 8'h0A;
    cyc();
    bus.p_wr = 1'b0;
    bus.adr  = '0;
    cyc();
    rd("t2_ie_kept", 16'hFFFF, 8'h15);
    rd("t2_if", 16'hFF0F, 8'hEA);
    chk_irq("t2_irq", 8'h00);
    // A strobe that never hits IF or IE commits nothing
    wr(16'hC000, 8'hFF);
    rd("t2_nomatch_if", 16'hFF0F, 8'hEA);
    rd("t2_nomatch_ie", 16'hFFFF, 8'h15);

    // Source edge beats iack in the same cycle
    wr(16'hFFFF, 8'h01);
    wr(16'hFF0F, 8'h01);
    src  = 8'h01;
    iack = 8'h01;
    cyc();
    iack = 8'h00;
    cyc();
    chk_irq("t3_irq", 8'h01);
    rd("t3_if", 16'hFF0F, 8'hE1);
    src = 8'h00;
    cyc();

    // Write commit beats iack in the same cycle
    wr(16'hFF0F, 8'h03);
    bus.adr  = 16'hFF0F;
    bus.din  = 8'h03;
    bus.p_wr = 1'b1;
    cyc();
    bus.p_wr = 1'b0;
    bus.adr  = '0;
    iack     = 8'h01;
    cyc();
    iack = 8'h00;
    rd("t4_if", 16'hFF0F, 8'hE3);
    chk_irq("t4_irq", 8'h01);
    // Multi-hot iack clears every acknowledged bit
    iack = 8'h03;
    cyc();
    iack = 8'h00;
    rd("t4_multi_if", 16'hFF0F, 8'hE0);
    chk_irq("t4_irq_clr", 8'h00);

    // Unimplemented line never sets IF or irq
    wr(16'hFFFF, 8'hFF);
    src = 8'h40;
    cyc();
    src = 8'h00;
    cyc();
    rd("t5_if", 16'hFF0F, 8'hE0);
    rd("t5_ie", 16'hFFFF, 8'hFF);
    chk_irq("t5_irq", 8'h00);

    // Async reset mid-write strobe, between clock edges
    wr(16'hFF0F, 8'h1F);
    chk_irq("t6_pre", 8'h1F);
    bus.adr  = 16'hFFFF;
    bus.din  = 8'h5A;
    bus.p_wr = 1'b1;
    cyc();
    bus.p_rd = 1'b1;
    #2 n_reset = 1'b0;
    #1;
    chk("t6_rst_irq", irq, 8'h00);
    chk("t6_rst_irq_any", {7'b0, irq_any}, 8'h00);
    chk("t6_rst_dout_oe", {7'b0, bus.dout_oe}, 8'h00);
    chk("t6_rst_dout", bus.dout, 8'h00);
    bus.p_rd = 1'b0;
    bus.p_wr = 1'b0;
    bus.adr  = '0;
    src      = 8'h01;
    cyc();
    #2 n_reset = 1'b1;
    cyc();
    rd("t6_if_first", 16'hFF0F, 8'hE1);
    rd("t6_ie", 16'hFFFF, 8'h00);
    chk_irq("t6_irq", 8'h00);
    src = 8'h00;
    cyc(2);

    chk("rd_queue_drained", 8'(rd_q.size()), 8'h00);
    chk("irq_queue_drained", 8'(irq_q.size()), 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
